// File: rtl/read_linear_split_pkg.sv
// -----------------------------------------------------------------------------
// read_linear_split_pkg
// Shared definitions for the read-stage linear address splitter:
//   - state_t   : FSM state encoding (3-bit)
//   - PAGE_SIZE : 4 KB page size at 13 bits so page-end sums never wrap
//   - MAX_LEN   : largest access length in bytes
//   - mask_bytes: zero every byte of a 64-bit word at index >= len
// -----------------------------------------------------------------------------
package read_linear_split_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_SECOND = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [12:0] PAGE_SIZE = 13'h1000;
    localparam logic [3:0]  MAX_LEN   = 4'd8;

    // Lengths at or above MAX_LEN keep the whole word.
    function automatic logic [63:0] mask_bytes(input logic [63:0] data,
                                               input logic [3:0]  len);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < len) begin
                m[i*8 +: 8] = 8'hFF;
            end
        end
        return data & m;
    endfunction

endpackage

// File: rtl/read_byte_merge.sv
// -----------------------------------------------------------------------------
// read_byte_merge
// Combinational little-endian merge of two TLB data words.
// The low word supplies bytes [0, i_len_lo), the high word supplies the next
// i_len_hi bytes; every byte outside those ranges is zero.
// Ports:
//   i_word_lo / i_len_lo : first word and its byte count
//   i_word_hi / i_len_hi : second word and its byte count (0 = unused)
//   o_merged             : i_word_lo masked | (i_word_hi masked << 8*i_len_lo)
// -----------------------------------------------------------------------------
module read_byte_merge
    import read_linear_split_pkg::*;
(
    input  logic [63:0] i_word_lo,
    input  logic [3:0]  i_len_lo,
    input  logic [63:0] i_word_hi,
    input  logic [3:0]  i_len_hi,
    output logic [63:0] o_merged
);

    logic [63:0] w_lo_masked;
    logic [63:0] w_hi_masked;
    logic [6:0]  w_shamt;

    assign w_lo_masked = mask_bytes(i_word_lo, i_len_lo);
    assign w_hi_masked = mask_bytes(i_word_hi, i_len_hi);
    // A shift of 64 (len_lo = 8) clears the high word, which is what we want.
    assign w_shamt     = {i_len_lo, 3'b000};
    assign o_merged    = w_lo_masked | (w_hi_masked << w_shamt);

endmodule

// File: rtl/read_linear_split.sv
// -----------------------------------------------------------------------------
// read_linear_split
// Turns one segment-checked linear read (up to 8 bytes) into one or two TLB
// read requests, splitting at a 4 KB page boundary, and merges the returned
// bytes into a single little-endian result.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rd_reset            : synchronous pipeline flush
//   read_do/address/length/cpl, rd_seg_fault : request from the read stage
//   tlbread_do/address/length/cpl            : request to the TLB (registered)
//   tlbread_done/page_fault/data             : TLB response
//   read_done, read_page_fault, read_data    : result to the read stage
//   dbg_state           : current FSM state
// Handshake: a TLB request is live while tlbread_do=1 and its fields are held
// stable; it completes in the cycle tlbread_done or tlbread_page_fault is high,
// and tlbread_do falls the following cycle.
// -----------------------------------------------------------------------------
module read_linear_split
    import read_linear_split_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_reset,
    input  logic        read_do,
    input  logic [31:0] read_address,
    input  logic [3:0]  read_length,
    input  logic [1:0]  read_cpl,
    input  logic        rd_seg_fault,
    output logic        tlbread_do,
    output logic [31:0] tlbread_address,
    output logic [3:0]  tlbread_length,
    output logic [1:0]  tlbread_cpl,
    input  logic        tlbread_done,
    input  logic        tlbread_page_fault,
    input  logic [63:0] tlbread_data,
    output logic        read_done,
    output logic        read_page_fault,
    output logic [63:0] read_data,
    output logic [2:0]  dbg_state
);

    state_t      r_state;
    logic [19:0] r_page;
    logic [3:0]  r_len1;
    logic [3:0]  r_len2;
    logic        r_split;
    logic [63:0] r_first;
    logic        r_tlbread_do;
    logic [31:0] r_tlbread_address;
    logic [3:0]  r_tlbread_length;
    logic [1:0]  r_tlbread_cpl;
    logic        r_read_done;
    logic        r_read_page_fault;
    logic [63:0] r_read_data;

    logic [12:0] w_end;
    logic        w_split;
    logic [3:0]  w_len1;
    logic [3:0]  w_len2;
    logic        w_accept;
    logic        w_resp;
    logic [63:0] w_lo_word;
    logic [3:0]  w_hi_len;
    logic [63:0] w_merged;

    // Page-crossing decision, done at 13 bits so offset+len cannot wrap.
    assign w_end   = {1'b0, read_address[11:0]} + {9'd0, read_length};
    assign w_split = (w_end > PAGE_SIZE);
    // When split, the offset sits within 15 bytes of the page end, so
    // PAGE_SIZE - offset equals 16 - offset[3:0] taken modulo 16.
    assign w_len1  = w_split ? (4'd0 - read_address[3:0]) : read_length;
    assign w_len2  = read_length - w_len1;

    assign w_accept = read_do && !rd_seg_fault && !rd_reset;
    assign w_resp   = tlbread_done || tlbread_page_fault;

    // FIRST masks the incoming word alone; SECOND appends it above the
    // already-masked first half.
    assign w_lo_word = (r_state == ST_FIRST) ? tlbread_data : r_first;
    assign w_hi_len  = (r_state == ST_SECOND) ? r_len2 : 4'd0;

    read_byte_merge u_merge (
        .i_word_lo (w_lo_word),
        .i_len_lo  (r_len1),
        .i_word_hi (tlbread_data),
        .i_len_hi  (w_hi_len),
        .o_merged  (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= ST_IDLE;
            r_page            <= '0;
            r_len1            <= '0;
            r_len2            <= '0;
            r_split           <= 1'b0;
            r_first           <= '0;
            r_tlbread_do      <= 1'b0;
            r_tlbread_address <= '0;
            r_tlbread_length  <= '0;
            r_tlbread_cpl     <= '0;
            r_read_done       <= 1'b0;
            r_read_page_fault <= 1'b0;
            r_read_data       <= '0;
        end else begin
            r_read_done       <= 1'b0;
            r_read_page_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_page        <= read_address[31:12];
                        r_len1        <= w_len1;
                        r_len2        <= w_len2;
                        r_split       <= w_split;
                        r_tlbread_cpl <= read_cpl;
                        if (read_length == 4'd0) begin
                            r_read_data <= '0;
                            r_read_done <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_tlbread_do      <= 1'b1;
                            r_tlbread_address <= read_address;
                            r_tlbread_length  <= w_len1;
                            r_state           <= ST_FIRST;
                        end
                    end
                end
                ST_FIRST, ST_SECOND: begin
                    if (!r_tlbread_do) begin
                        // One idle cycle between the two halves; nothing is
                        // outstanding, so a flush can return straight to IDLE.
                        if (rd_reset) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_tlbread_do <= 1'b1;
                        end
                    end else if (rd_reset) begin
                        // A response landing in the flush cycle is simply
                        // dropped; otherwise wait for it in DRAIN.
                        if (w_resp) begin
                            r_tlbread_do <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (tlbread_page_fault) begin
                        r_tlbread_do      <= 1'b0;
                        r_read_page_fault <= 1'b1;
                        r_state           <= ST_IDLE;
                    end else if (tlbread_done) begin
                        r_tlbread_do <= 1'b0;
                        if (r_state == ST_FIRST && r_split) begin
                            r_first           <= w_merged;
                            r_tlbread_address <= {r_page + 20'd1, 12'h000};
                            r_tlbread_length  <= r_len2;
                            r_state           <= ST_SECOND;
                        end else begin
                            r_read_data <= w_merged;
                            r_read_done <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_resp) begin
                        r_tlbread_do <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_tlbread_do <= 1'b0;
                end
            endcase
        end
    end

    assign tlbread_do      = r_tlbread_do;
    assign tlbread_address = r_tlbread_address;
    assign tlbread_length  = r_tlbread_length;
    assign tlbread_cpl     = r_tlbread_cpl;
    assign read_done       = r_read_done;
    assign read_page_fault = r_read_page_fault;
    assign read_data       = r_read_data;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_read_linear_split.sv
// -----------------------------------------------------------------------------
// tb_read_linear_split
// Directed bench for read_linear_split. A byte-level model computes the TLB
// requests and the merged result of each access; a monitor compares the DUT
// against those expectations every cycle.
// -----------------------------------------------------------------------------
module tb_read_linear_split;

    logic        clk;
    logic        rst_n;
    logic        rd_reset;
    logic        read_do;
    logic [31:0] read_address;
    logic [3:0]  read_length;
    logic [1:0]  read_cpl;
    logic        rd_seg_fault;
    logic        tlbread_do;
    logic [31:0] tlbread_address;
    logic [3:0]  tlbread_length;
    logic [1:0]  tlbread_cpl;
    logic        tlbread_done;
    logic        tlbread_page_fault;
    logic [63:0] tlbread_data;
    logic        read_done;
    logic        read_page_fault;
    logic [63:0] read_data;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // {address, length, cpl} of each expected TLB request
    logic [37:0] exp_req_q[$];
    // {kind, data}: kind 1 = read_done, 2 = read_page_fault
    logic [65:0] exp_q[$];
    logic [63:0] m_read_data;

    read_linear_split dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rd_reset           (rd_reset),
        .read_do            (read_do),
        .read_address       (read_address),
        .read_length        (read_length),
        .read_cpl           (read_cpl),
        .rd_seg_fault       (rd_seg_fault),
        .tlbread_do         (tlbread_do),
        .tlbread_address    (tlbread_address),
        .tlbread_length     (tlbread_length),
        .tlbread_cpl        (tlbread_cpl),
        .tlbread_done       (tlbread_done),
        .tlbread_page_fault (tlbread_page_fault),
        .tlbread_data       (tlbread_data),
        .read_done          (read_done),
        .read_page_fault    (read_page_fault),
        .read_data          (read_data),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Byte-level model: bytes before the page end come from the first TLB
    // word, the rest from the second word starting at its byte 0.
    function automatic void model_push(input logic [31:0] addr, input logic [3:0] len,
                                       input logic [1:0] cpl, input logic [63:0] d1,
                                       input logic [63:0] d2, input int fault_at);
        int left, n1, n2;
        logic [63:0] res;
        left = 4096 - int'(addr[11:0]);
        n1 = (int'(len) <= left) ? int'(len) : left;
        n2 = int'(len) - n1;
        res = '0;
        for (int i = 0; i < int'(len); i++) begin
            if (i < n1) res[8*i +: 8] = d1[8*i +: 8];
            else        res[8*i +: 8] = d2[8*(i-n1) +: 8];
        end
        if (len != 4'd0) begin
            exp_req_q.push_back({addr, 4'(n1), cpl});
            if (n2 > 0) exp_req_q.push_back({addr + 32'(n1), 4'(n2), cpl});
        end
        if ((fault_at == 0 && len != 4'd0) || (fault_at == 1 && n2 > 0)) begin
            exp_q.push_back({2'd2, m_read_data});
        end else begin
            exp_q.push_back({2'd1, res});
            m_read_data = res;
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_do;
        logic [37:0] prev_req;
        logic [37:0] cur;
        logic [37:0] exp_req;
        logic [65:0] ev;
        prev_do  = 1'b0;
        prev_req = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_do = 1'b0;
            end else begin
                cur = {tlbread_address, tlbread_length, tlbread_cpl};
                if (tlbread_do && !prev_do) begin
                    if (exp_req_q.size() == 0) begin
                        check("unexpected_tlb_req", 64'(cur), 64'd0);
                    end else begin
                        exp_req = exp_req_q.pop_front();
                        check("tlb_req", 64'(cur), 64'(exp_req));
                    end
                end else if (tlbread_do) begin
                    check("tlb_req_stable", 64'(cur), 64'(prev_req));
                end
                if (read_done || read_page_fault) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", {62'd0, read_page_fault, read_done}, 64'd0);
                    end else begin
                        ev = exp_q.pop_front();
                        check("event_kind", {62'd0, read_page_fault, read_done}, {62'd0, ev[65:64]});
                        check("read_data", read_data, ev[63:0]);
                    end
                end
                prev_do  = tlbread_do;
                prev_req = cur;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drives one access and plays a TLB that answers `lat` cycles into each
    // request. fault_at selects which request (0/1) faults; -1 for none.
    // done_cyc: negedge index (0 = cycle after accept) of the final pulse.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] cpl,
                           input logic [63:0] d1, input logic [63:0] d2, input int lat,
                           input int fault_at, output int done_cyc);
        int  req_idx;
        int  wait_cnt;
        bit  fin;
        model_push(addr, len, cpl, d1, d2, fault_at);
        @(negedge clk);
        tlbread_done       = 1'b0;
        tlbread_page_fault = 1'b0;
        read_do      = 1'b1;
        read_address = addr;
        read_length  = len;
        read_cpl     = cpl;
        req_idx  = 0;
        wait_cnt = 0;
        fin      = 1'b0;
        done_cyc = -1;
        for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
            @(negedge clk);
            tlbread_done       = 1'b0;
            tlbread_page_fault = 1'b0;
            if (cyc == 0) begin
                check("accept_latency", {63'd0, (len == 4'd0) ? read_done : tlbread_do}, 64'd1);
            end
            if (read_done || read_page_fault) begin
                read_do  = 1'b0;
                fin      = 1'b1;
                done_cyc = cyc;
            end else if (tlbread_do) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    tlbread_data = (req_idx == 0) ? d1 : d2;
                    if (req_idx == fault_at) tlbread_page_fault = 1'b1;
                    else                     tlbread_done       = 1'b1;
                    req_idx++;
                    wait_cnt = 0;
                end
            end
        end
        if (!fin) begin
            read_do = 1'b0;
            check("txn_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic check_drained();
        @(negedge clk);
        #1;
        check("event_queue_empty", 64'(exp_q.size()), 64'd0);
        check("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
        check("pulses_low", {62'd0, read_page_fault, read_done}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tlbread_do"}, {63'd0, tlbread_do}, 64'd0);
        check({tag, "_tlbread_address"}, {32'd0, tlbread_address}, 64'd0);
        check({tag, "_tlbread_length"}, {60'd0, tlbread_length}, 64'd0);
        check({tag, "_tlbread_cpl"}, {62'd0, tlbread_cpl}, 64'd0);
        check({tag, "_read_done"}, {63'd0, read_done}, 64'd0);
        check({tag, "_read_page_fault"}, {63'd0, read_page_fault}, 64'd0);
        check({tag, "_read_data"}, read_data, 64'd0);
        check({tag, "_state"}, {61'd0, dbg_state}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dc;
        rst_n = 1'b0; rd_reset = 1'b0; read_do = 1'b0; read_address = '0;
        read_length = '0; read_cpl = '0; rd_seg_fault = 1'b0;
        tlbread_done = 1'b0; tlbread_page_fault = 1'b0; tlbread_data = '0;
        m_read_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Non-split read, 1-cycle TLB
        run_txn(32'h0000_1FF0, 4'd4, 2'd1, 64'h1122334455667788, 64'h0, 1, -1, dc);
        check("nonsplit_done_cycle", 64'(dc), 64'd1);
        check("nonsplit_data", read_data, 64'h0000000055667788);
        check_drained();

        // Page-split read
        run_txn(32'h0000_2FFD, 4'd8, 2'd2, 64'hDEADBEEF00CCBBAA, 64'hFFEEDD5544332211, 1, -1, dc);
        check("split_done_cycle", 64'(dc), 64'd3);
        check("split_data", read_data, 64'h5544332211CCBBAA);
        check_drained();

        // Fault on the second half: read_data keeps the previous result
        run_txn(32'h0000_0FFC, 4'd8, 2'd0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 2, 1, dc);
        check("fault2_data_kept", read_data, 64'h5544332211CCBBAA);
        check_drained();

        // Fault on a single request
        run_txn(32'h1234_5678, 4'd2, 2'd3, 64'h00000000000055AA, 64'h0, 1, 0, dc);
        check_drained();

        // Access ending exactly at the page end does not split
        run_txn(32'h0000_0FF8, 4'd8, 2'd1, 64'h8877665544332211, 64'h0, 3, -1, dc);
        check("pageend_done_cycle", 64'(dc), 64'd3);
        check("pageend_data", read_data, 64'h8877665544332211);
        check_drained();

        // Segment fault blocks issue
        @(negedge clk);
        read_do = 1'b1; rd_seg_fault = 1'b1; read_address = 32'h0000_4000; read_length = 4'd4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("segfault_no_issue", {63'd0, tlbread_do}, 64'd0);
        end
        read_do = 1'b0; rd_seg_fault = 1'b0;
        check_drained();

        // Zero length
        run_txn(32'h00AB_C123, 4'd0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, -1, dc);
        check("zerolen_done_cycle", 64'(dc), 64'd0);
        check("zerolen_data", read_data, 64'd0);
        check_drained();

        // Flush during FIRST with the TLB stalled for 5 cycles
        exp_req_q.push_back({32'h5000_0100, 4'd4, 2'd3});
        @(negedge clk);
        read_do = 1'b1; read_address = 32'h5000_0100; read_length = 4'd4; read_cpl = 2'd3;
        @(negedge clk);
        check("flush_req_up", {63'd0, tlbread_do}, 64'd1);
        rd_reset = 1'b1; read_do = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_reset = 1'b0;
            check("flush_req_held", {63'd0, tlbread_do}, 64'd1);
        end
        tlbread_data = 64'hAAAA_BBBB_CCCC_DDDD;
        tlbread_done = 1'b1;
        // The next access must be accepted the cycle after the drain ends
        run_txn(32'h0000_7010, 4'd3, 2'd0, 64'h0000000000332211, 64'h0, 1, -1, dc);
        check("after_flush_data", read_data, 64'h0000000000332211);
        check_drained();

        // 32-bit address wrap on the second request
        run_txn(32'hFFFF_FFFE, 4'd4, 2'd2, 64'h999999999999BBAA, 64'h777777777777DDCC, 1, -1, dc);
        check("wrap_data", read_data, 64'h00000000DDCCBBAA);
        check_drained();

        // Asynchronous reset while the second request is outstanding
        model_push(32'hFFFF_FFFD, 4'd8, 2'd1, 64'h0000000000332211, 64'h0, -1);
        @(negedge clk);
        read_do = 1'b1; read_address = 32'hFFFF_FFFD; read_length = 4'd8; read_cpl = 2'd1;
        @(negedge clk);
        check("areset_first_up", {63'd0, tlbread_do}, 64'd1);
        tlbread_data = 64'h0000000000332211;
        tlbread_done = 1'b1;
        @(negedge clk);
        tlbread_done = 1'b0;
        check("areset_gap", {63'd0, tlbread_do}, 64'd0);
        @(negedge clk);
        check("areset_second_up", {63'd0, tlbread_do}, 64'd1);
        check("areset_second_addr", {32'd0, tlbread_address}, 64'd0);
        check("areset_second_len", {60'd0, tlbread_length}, 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        exp_q.delete();
        exp_req_q.delete();
        m_read_data = '0;
        read_do = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Normal operation after reset
        run_txn(32'h0000_0100, 4'd8, 2'd1, 64'h0F0E0D0C0B0A0908, 64'h0, 2, -1, dc);
        check("post_reset_data", read_data, 64'h0F0E0D0C0B0A0908);
        check_drained();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
